simd_cpu: RTL and testbench

- Byte-serial 4-lane 8-bit SIMD processor with a 32-entry vector register file and a 32-entry vector data memory.
- Instructions arrive on instr_i one byte per clock, framed by a start byte (0xFE) and an end byte (0xFF), and execute as they stream in.
- A combinational debug read port exposes any single lane of any register or memory word.
- Top-level compute core of the lab design.

---
 rtl/simd_cpu_pkg.sv | 32 +++
 rtl/simd_alu.sv | 60 ++++++
 rtl/simd_cpu.sv | 143 ++++++++++++++
 tb/tb_simd_cpu.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_cpu_pkg.sv
// Shared constants, opcodes and controller state type for the byte-serial SIMD core.
// Build option: define SIMD_SATURATE_EN for saturating VADD/VSUB.
package simd_cpu_pkg;

    localparam int unsigned NREG  = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned LW    = 8;
    localparam int unsigned VW    = LANES * LW;

    localparam logic [7:0] START_BYTE = 8'hFE;
    localparam logic [7:0] END_BYTE   = 8'hFF;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_VADD  = 8'h01;
    localparam logic [7:0] OP_VSUB  = 8'h02;
    localparam logic [7:0] OP_VMUL  = 8'h03;
    localparam logic [7:0] OP_VRELU = 8'h04;
    localparam logic [7:0] OP_SETL  = 8'h05;
    localparam logic [7:0] OP_VLD   = 8'h06;
    localparam logic [7:0] OP_VST   = 8'h07;
    localparam logic [7:0] OP_VMAX  = 8'h08;

    localparam logic [LW-1:0] SAT_MAX = 8'h7F;
    localparam logic [LW-1:0] SAT_MIN = 8'h80;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } state_e;

endpackage

// File: rtl/simd_alu.sv
// Combinational lane-wise arithmetic for the SIMD core; flags signed overflow of VADD/VSUB.
// Build option: SIMD_SATURATE_EN clamps VADD/VSUB results instead of wrapping.
module simd_alu
    import simd_cpu_pkg::*;
(
    input  logic [7:0]    op,
    input  logic [VW-1:0] a,
    input  logic [VW-1:0] b,
    output logic [VW-1:0] y,
    output logic          ovf
);

    logic [LANES-1:0] lane_ovf;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LW-1:0] la, lb, sum, dif, prod, res;
        logic          add_ovf, sub_ovf, lovf;

        assign la   = a[i*LW +: LW];
        assign lb   = b[i*LW +: LW];
        assign sum  = la + lb;
        assign dif  = la - lb;
        // Low byte of a two's-complement product is sign-agnostic.
        assign prod = la * lb;

        assign add_ovf = (la[LW-1] == lb[LW-1]) && (sum[LW-1] != la[LW-1]);
        assign sub_ovf = (la[LW-1] != lb[LW-1]) && (dif[LW-1] != la[LW-1]);

        always_comb begin
            res  = '0;
            lovf = 1'b0;
            case (op)
                OP_VADD: begin
                    res  = sum;
                    lovf = add_ovf;
`ifdef SIMD_SATURATE_EN
                    if (add_ovf) res = la[LW-1] ? SAT_MIN : SAT_MAX;
`endif
                end
                OP_VSUB: begin
                    res  = dif;
                    lovf = sub_ovf;
`ifdef SIMD_SATURATE_EN
                    if (sub_ovf) res = la[LW-1] ? SAT_MIN : SAT_MAX;
`endif
                end
                OP_VMUL:  res = prod;
                OP_VRELU: res = la[LW-1] ? '0 : la;
                OP_VMAX:  res = ($signed(la) > $signed(lb)) ? la : lb;
                default:  res = '0;
            endcase
        end

        assign y[i*LW +: LW] = res;
        assign lane_ovf[i]   = lovf;
    end

    assign ovf = |lane_ovf;

endmodule

// File: rtl/simd_cpu.sv
// Byte-serial 4-lane SIMD processor: framed instruction stream, vector register file,
// vector data memory and a combinational debug read port. Option: SIMD_SATURATE_EN.
module simd_cpu
    import simd_cpu_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset,
    input  logic [7:0] instr_i,
    input  logic       DataOrReg,
    input  logic [4:0] address,
    input  logic [1:0] vout_addr,
    output logic [7:0] value_o,
    output logic       is_positive,
    output logic [2:0] easter_egg
);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q;
    logic [7:0]    op_q;
    logic [4:0]    rd_q, rs1_q;
    logic          ovf_q;
    logic          running, halted;

    logic [VW-1:0] regs [NREG];
    logic [VW-1:0] mem  [NREG];

    logic          exec, reg_we, mem_we, ovf_set;
    logic [VW-1:0] va, vb, vd, alu_y, setl_vec, reg_wdata, dbg_vec;
    logic          alu_ovf;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (instr_i == START_BYTE) state_d = StRun;
            StRun:   if (cnt_q == 2'd0 && instr_i == END_BYTE) state_d = StHalt;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        running = (state_q == StRun);
        halted  = (state_q == StHalt);
    end

    // Byte slot sequencer; 0xFE in the opcode slot is swallowed as a 1-byte no-op.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            cnt_q <= 2'd0;
            op_q  <= OP_NOP;
            rd_q  <= '0;
            rs1_q <= '0;
        end else if (state_q == StRun) begin
            case (cnt_q)
                2'd0: begin
                    if (instr_i != START_BYTE && instr_i != END_BYTE) begin
                        op_q  <= instr_i;
                        cnt_q <= 2'd1;
                    end
                end
                2'd1: begin
                    rd_q  <= instr_i[4:0];
                    cnt_q <= 2'd2;
                end
                2'd2: begin
                    rs1_q <= instr_i[4:0];
                    cnt_q <= 2'd3;
                end
                default: cnt_q <= 2'd0;
            endcase
        end
    end

    assign exec = (state_q == StRun) && (cnt_q == 2'd3);
    assign va   = regs[rs1_q];
    assign vb   = regs[instr_i[4:0]];
    assign vd   = regs[rd_q];

    simd_alu u_alu (
        .op  (op_q),
        .a   (va),
        .b   (vb),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    always_comb begin
        setl_vec = vd;
        setl_vec[int'(rs1_q[1:0])*LW +: LW] = instr_i;
    end

    always_comb begin
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        ovf_set   = 1'b0;
        reg_wdata = alu_y;
        if (exec) begin
            case (op_q)
                OP_VADD, OP_VSUB: begin
                    reg_we  = 1'b1;
                    ovf_set = alu_ovf;
                end
                OP_VMUL, OP_VRELU, OP_VMAX: reg_we = 1'b1;
                OP_SETL: begin
                    reg_we    = 1'b1;
                    reg_wdata = setl_vec;
                end
                OP_VLD: begin
                    reg_we    = 1'b1;
                    reg_wdata = mem[rs1_q];
                end
                OP_VST:  mem_we = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                mem[i]  <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            if (reg_we)  regs[rd_q] <= reg_wdata;
            if (mem_we)  mem[rs1_q] <= vd;
            if (ovf_set) ovf_q      <= 1'b1;
        end
    end

    always_comb begin
        dbg_vec     = DataOrReg ? regs[address] : mem[address];
        value_o     = dbg_vec[int'(vout_addr)*LW +: LW];
        is_positive = ~value_o[LW-1] & (|value_o);
        easter_egg  = {halted, running, ovf_q};
    end

endmodule

// File: tb/tb_simd_cpu.sv
// Self-checking bench for simd_cpu: instruction table plus scoreboard of expected debug reads.
module tb_simd_cpu;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr_i;
    logic       dor;
    logic [4:0] address;
    logic [1:0] lane;
    logic [7:0] value_o;
    logic       is_positive;
    logic [2:0] easter_egg;

    int checks = 0;
    int errors = 0;
    logic [7:0] fill;
    logic       ovf_model;

    simd_cpu dut (
        .clk_i       (clk),
        .reset       (reset),
        .instr_i     (instr_i),
        .DataOrReg   (dor),
        .address     (address),
        .vout_addr   (lane),
        .value_o     (value_o),
        .is_positive (is_positive),
        .easter_egg  (easter_egg)
    );

    always #10 clk = ~clk;

`ifdef SIMD_SATURATE_EN
    localparam logic [31:0] EXP_VADD = 32'h807FEC14;
    localparam logic [31:0] EXP_VSUB = 32'h7F000A00;
    localparam bit          SAT      = 1'b1;
`else
    localparam logic [31:0] EXP_VADD = 32'h00FEEC14;
    localparam logic [31:0] EXP_VSUB = 32'h80000A00;
    localparam bit          SAT      = 1'b0;
`endif

    typedef struct {
        string      name;
        logic       d;
        logic [4:0] a;
        logic [1:0] l;
        logic [7:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        d;
        logic [4:0]  a;
        logic [31:0] expv;
        logic [2:0]  egg;
    } vec_t;

    sb_t  sbq[$];
    vec_t tbl[14];

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        instr_i = b;
        @(posedge clk);
        #1;
        instr_i = fill;
    endtask

    task automatic send_instr(input logic [31:0] ins);
        for (int k = 3; k >= 0; k--) send(ins[k*8 +: 8]);
    endtask

    task automatic push_vec(input string name, input logic d, input logic [4:0] a,
                            input logic [31:0] v);
        sb_t e;
        for (int k = 0; k < 4; k++) begin
            e.name = name;
            e.d    = d;
            e.a    = a;
            e.l    = 2'(k);
            e.exp  = v[k*8 +: 8];
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        sb_t  e;
        logic exp_pos;
        while (sbq.size() > 0) begin
            e       = sbq.pop_front();
            dor     = e.d;
            address = e.a;
            lane    = e.l;
            #1;
            checks++;
            if (value_o !== e.exp) begin
                errors++;
                $display("FAIL %s lane %0d: value_o=%h expected %h", e.name, e.l, value_o, e.exp);
            end
            exp_pos = ($signed(e.exp) > 0);
            checks++;
            if (is_positive !== exp_pos) begin
                errors++;
                $display("FAIL %s lane %0d: is_positive=%b expected %b", e.name, e.l,
                         is_positive, exp_pos);
            end
        end
    endtask

    task automatic check_egg(input string name, input logic [2:0] exp);
        checks++;
        if (easter_egg !== exp) begin
            errors++;
            $display("FAIL %s: easter_egg=%b expected %b", name, easter_egg, exp);
        end
    endtask

    function automatic logic [7:0] lane_model(input logic [7:0] op, input logic [7:0] a,
                                              input logic [7:0] b, output logic ov);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        ov = 1'b0;
        case (op)
            8'h01:   r = sa + sb;
            8'h02:   r = sa - sb;
            8'h03:   r = sa * sb;
            8'h04:   r = (sa < 0) ? 0 : sa;
            8'h08:   r = (sa > sb) ? sa : sb;
            default: r = 0;
        endcase
        if ((op == 8'h01 || op == 8'h02) && (r > 127 || r < -128)) begin
            ov = 1'b1;
            if (SAT) r = (r > 127) ? 127 : -128;
        end
        return 8'(r);
    endfunction

    initial begin
        logic [7:0]  ops[5];
        logic [31:0] a_vec, b_vec, e_vec;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic        ov;

        ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h08};
        tbl[0]  = '{"setl_l0",   32'h0502000A, 1'b1, 5'd2,  32'h0000000A, 3'b010};
        tbl[1]  = '{"setl_l1",   32'h050201F6, 1'b1, 5'd2,  32'h0000F60A, 3'b010};
        tbl[2]  = '{"setl_l2",   32'h0502027F, 1'b1, 5'd2,  32'h007FF60A, 3'b010};
        tbl[3]  = '{"setl_l3",   32'h05020380, 1'b1, 5'd2,  32'h807FF60A, 3'b010};
        tbl[4]  = '{"vrelu",     32'h04030200, 1'b1, 5'd3,  32'h007F000A, 3'b010};
        tbl[5]  = '{"vadd",      32'h01040202, 1'b1, 5'd4,  EXP_VADD,     3'b011};
        tbl[6]  = '{"vst",       32'h07020500, 1'b0, 5'd5,  32'h807FF60A, 3'b011};
        tbl[7]  = '{"vld",       32'h06060500, 1'b1, 5'd6,  32'h807FF60A, 3'b011};
        tbl[8]  = '{"vmul",      32'h03070202, 1'b1, 5'd7,  32'h00016464, 3'b011};
        tbl[9]  = '{"vmax",      32'h08080203, 1'b1, 5'd8,  32'h007F000A, 3'b011};
        tbl[10] = '{"vsub",      32'h02090302, 1'b1, 5'd9,  EXP_VSUB,     3'b011};
        tbl[11] = '{"bad_op",    32'h20090202, 1'b1, 5'd9,  EXP_VSUB,     3'b011};
        tbl[12] = '{"setl_ff",   32'h050D00FF, 1'b1, 5'd13, 32'h000000FF, 3'b011};
        tbl[13] = '{"setl_fefe", 32'h050DFEFE, 1'b1, 5'd13, 32'h00FE00FF, 3'b011};

        reset = 1'b1; instr_i = 8'h00; fill = 8'h00; dor = 1'b0; address = '0; lane = '0;
        repeat (2) @(posedge clk);
        #1;
        push_vec("rst_r0",   1'b1, 5'd0,  32'h0);
        push_vec("rst_r31",  1'b1, 5'd31, 32'h0);
        push_vec("rst_m0",   1'b0, 5'd0,  32'h0);
        push_vec("rst_m31",  1'b0, 5'd31, 32'h0);
        drain();
        check_egg("rst_egg", 3'b000);
        @(negedge clk);
        reset = 1'b0;

        // Stream before the start byte must be ignored.
        for (int i = 0; i < 4; i++) send_instr(tbl[i].ins);
        push_vec("idle_r2", 1'b1, 5'd2, 32'h0);
        drain();
        check_egg("idle_egg", 3'b000);

        send(8'hFE);
        fill = 8'hFE;
        check_egg("run_egg", 3'b010);
        for (int i = 0; i < 14; i++) begin
            send_instr(tbl[i].ins);
            push_vec(tbl[i].name, tbl[i].d, tbl[i].a, tbl[i].expv);
            drain();
            check_egg({tbl[i].name, "_egg"}, tbl[i].egg);
        end
        ovf_model = 1'b1;

        // Random operands through the model; odd iterations write back over rs1.
        for (int i = 0; i < 8; i++) begin
            a_vec = $urandom;
            b_vec = $urandom;
            op    = ops[$urandom_range(0, 4)];
            rd    = i[0] ? 5'd10 : 5'd12;
            for (int k = 0; k < 4; k++) begin
                send_instr({8'h05, 3'($urandom), 5'd10, 6'b0, 2'(k), a_vec[k*8 +: 8]});
                send_instr({8'h05, 3'($urandom), 5'd11, 6'b0, 2'(k), b_vec[k*8 +: 8]});
            end
            for (int k = 0; k < 4; k++) begin
                e_vec[k*8 +: 8] = lane_model(op, a_vec[k*8 +: 8], b_vec[k*8 +: 8], ov);
                ovf_model |= ov;
            end
            send_instr({op, 3'($urandom), rd, 3'($urandom), 5'd10, 8'h0B});
            push_vec($sformatf("rand%0d_op%0h", i, op), 1'b1, rd, e_vec);
            drain();
            check_egg("rand_egg", {2'b01, ovf_model});
        end

        send(8'hFF);
        check_egg("halt_egg", {2'b10, ovf_model});
        send_instr(32'h05020055);
        push_vec("halt_setl", 1'b1, 5'd2, 32'h807FF60A);
        drain();

        // Reset in the middle of an instruction.
        reset = 1'b1;
        #5;
        reset = 1'b0;
        fill = 8'h00;
        send(8'hFE);
        fill = 8'hFE;
        check_egg("rerun_egg", 3'b010);
        send(8'h05);
        send(8'h02);
        #2;
        reset = 1'b1;
        instr_i = 8'h00;
        fill = 8'h00;
        #1;
        push_vec("mid_rst_r2", 1'b1, 5'd2, 32'h0);
        push_vec("mid_rst_m5", 1'b0, 5'd5, 32'h0);
        drain();
        check_egg("mid_rst_egg", 3'b000);
        @(negedge clk);
        reset = 1'b0;
        send(8'h33);
        send(8'h02);
        check_egg("post_rst_idle", 3'b000);
        send(8'hFE);
        fill = 8'hFE;
        send_instr(32'h05020033);
        push_vec("post_rst_setl", 1'b1, 5'd2, 32'h00000033);
        drain();
        check_egg("post_rst_egg", 3'b010);
        send(8'hFF);
        check_egg("final_halt", 3'b100);
        send_instr(32'h05020155);
        push_vec("final_halt_setl", 1'b1, 5'd2, 32'h00000033);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
